mode_change_ctrl: RTL and testbench
===================================

// Module: mode_change_ctrl
// PURPOSE
// Upstream stage of the TDM controller: holds the per-mode schedule-table bounds and drives
// stbl_min/stbl_maxp1 into it. Accepts mode-change requests from the config bus. Each request
// commits on the period boundary that ends the TDM period whose mc_p_cnt equals the requested
// target, so every NI on the NoC switches schedule in the same period.
// PARAMETERS
// NMODES       4    number of schedule modes (2..8); table depth
// RST_MAXP1    1    reset value of every table entry's maxp1 field (min field resets to 0)
// PORTS
// clk               in   1   system clock
// reset             in   1   asynchronous, active-high reset
// config_addr       in   14  config word address; [10:0] decoded
// config_en         in   1   config access strobe
// config_wr         in   1   1=write, 0=read
// config_wdata      in   32  write data
// sel               in   1   block select (access valid only when sel & config_en)
// config_slv_rdata  out  32  read data, registered, 1-cycle latency
// config_slv_error  out  1   access error, registered, aligned with rdata
// period_boundary   in   1   1-cycle pulse from TDM controller at schedule wrap
// mc_p_cnt          in   2   period counter from TDM controller (increments cycle after boundary)
// stbl_min          out  8   first slot index of schedule to load at next wrap
// stbl_maxp1        out  8   last slot index + 1 of running schedule
// cur_mode          out  3   active mode
// mc_pending        out  1   a mode change is armed and not yet committed
// BEHAVIOUR
// Reset: all outputs 0 except stbl_maxp1=RST_MAXP1; cur_mode=0; FSM=IDLE; table min=0, maxp1=RST_MAXP1.
// Register map (addr[10:0]); access = sel & config_en; rdata/error valid the following cycle:
//  0x000 REQ    W: [2:0]=new mode, [9:8]=target p_cnt. R: {22'b0,tgt[9:8],5'b0,cur_mode[2:0]}
//  0x001 STAT   R only: [0]=mc_pending, [6:4]=pending mode, [9:8]=target. Write -> error.
//  0x002+m TBL  m<NMODES. W: [7:0]=min, [15:8]=maxp1. R: same layout, upper bits 0.
//  Any other address -> error=1, rdata=0, no side effect. Non-error reads: error=0.
// REQ write rules: mode>=NMODES -> error, discarded. While ARMED -> error, discarded (no queue).
//  mode==cur_mode while IDLE -> accepted, no-op, stays IDLE, no error.
// TBL write to entry of cur_mode, or of pending mode while ARMED -> error, discarded.
// FSM:
//  IDLE  : valid REQ write -> latch pend_mode, tgt; -> ARMED; mc_pending=1 next cycle.
//  ARMED : when period_boundary=1 and mc_p_cnt==tgt -> COMMIT. Other boundaries ignored.
//  COMMIT: 1 cycle; cur_mode<=pend_mode; stbl_maxp1<=tbl[pend].maxp1; mc_pending<=0; -> IDLE.
// stbl_min register: next = tbl[pend].min if (ARMED && mc_p_cnt==tgt) else tbl[cur_mode].min.
//  New min is therefore visible from 1 cycle after mc_p_cnt reaches tgt, and is sampled by the
//  TDM controller at the committing boundary; stbl_maxp1 switches only the cycle after that
//  boundary (old schedule finishes its period on old bounds). Requires TDM period >= 2 cycles.
// Boundary with mc_p_cnt==tgt in the same cycle as REQ write (IDLE): not committed; waits 4 periods.
// Simultaneous REQ write and COMMIT cycle: FSM not IDLE -> error, discarded.
// mc_p_cnt wrap 3->0 handled by plain 2-bit equality; no arithmetic on tgt.
// No check that min<maxp1; table contents are software's responsibility.
// Reset asserted mid-ARMED: pending request dropped, all state to reset values immediately.
// TESTING
// 1 Write TBL1={min=0x10,maxp1=0x18}; read TBL1 -> rdata 0x0000_1810, error 0, one cycle later.
// 2 mc_p_cnt=1, REQ mode=1 tgt=2; boundaries at p_cnt 1 ignored; at p_cnt 2 stbl_min=0x10
//   before the boundary, stbl_maxp1=0x18 and cur_mode=1 the cycle after it; mc_pending falls.
// 3 REQ while ARMED, REQ mode=NMODES, write STAT, addr 0x7FF -> error=1 each, state unchanged.
// 4 Write TBL of cur_mode, and of pending mode while ARMED -> error=1, entry unchanged on read.
// 5 REQ mode==cur_mode -> error=0, mc_pending stays 0, outputs unchanged.
// 6 Assert reset async while ARMED (between clock edges) -> outputs at reset values at once; no commit.

Source files
------------

// File: rtl/mode_change_if.sv
// Config-bus bundle between the register master and the mode-change controller.
interface mode_change_if;
    logic [13:0] config_addr;
    logic        config_en;
    logic        config_wr;
    logic [31:0] config_wdata;
    logic        sel;
    logic [31:0] config_slv_rdata;
    logic        config_slv_error;

    modport master (
        output config_addr, config_en, config_wr, config_wdata, sel,
        input  config_slv_rdata, config_slv_error
    );

    modport slave (
        input  config_addr, config_en, config_wr, config_wdata, sel,
        output config_slv_rdata, config_slv_error
    );
endinterface

// File: rtl/mode_change_ctrl.sv
// Mode-change controller: per-mode schedule bounds table plus an armed request that commits
// on the period boundary whose period counter matches the requested target.
//
// state  | meaning
// IDLE   | no request outstanding; REQ writes accepted
// ARMED  | request latched, waiting for boundary with mc_p_cnt == tgt
// COMMIT | one-cycle settle after switching cur_mode; REQ writes rejected
module mode_change_ctrl #(
    parameter int NMODES    = 4,
    parameter int RST_MAXP1 = 1
) (
    input  logic         clk,
    input  logic         reset,
    mode_change_if.slave cfg,
    input  logic         period_boundary,
    input  logic [1:0]   mc_p_cnt,
    output logic [7:0]   stbl_min,
    output logic [7:0]   stbl_maxp1,
    output logic [2:0]   cur_mode,
    output logic         mc_pending
);
    typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_t;
    state_t state, state_next;

    // Sized for the 3-bit mode field; entries at or above NMODES are never written.
    logic [7:0]  tbl_min   [8];
    logic [7:0]  tbl_maxp1 [8];
    logic [2:0]  pend_mode;
    logic [1:0]  tgt;

    logic        access, wr;
    logic [10:0] addr;
    logic        is_req, is_stat, is_tbl;
    logic [2:0]  tbl_idx;
    logic [2:0]  req_mode;
    logic        req_err, req_valid, tbl_err, tbl_we, tgt_hit, commit;
    logic [31:0] rdata_next;
    logic        err_next;

    logic        unused_bits;
    assign unused_bits = ^{cfg.config_addr[13:11], cfg.config_wdata[31:16]};

    always_comb begin
        access    = cfg.sel & cfg.config_en;
        wr        = access & cfg.config_wr;
        addr      = cfg.config_addr[10:0];
        is_req    = (addr == 11'd0);
        is_stat   = (addr == 11'd1);
        is_tbl    = (addr >= 11'd2) && (addr < 11'(NMODES + 2));
        tbl_idx   = 3'(addr - 11'd2);
        req_mode  = cfg.config_wdata[2:0];
        req_err   = ({1'b0, req_mode} >= 4'(NMODES)) || (state != IDLE);
        req_valid = wr && is_req && !req_err && (req_mode != cur_mode);
        tbl_err   = (tbl_idx == cur_mode) || ((state == ARMED) && (tbl_idx == pend_mode));
        tbl_we    = wr && is_tbl && !tbl_err;
        tgt_hit   = (state == ARMED) && (mc_p_cnt == tgt);
        commit    = tgt_hit && period_boundary;

        rdata_next = '0;
        err_next   = 1'b0;
        if (access) begin
            if (is_req) begin
                if (cfg.config_wr) err_next = req_err;
                else rdata_next = {22'b0, tgt, 5'b0, cur_mode};
            end else if (is_stat) begin
                if (cfg.config_wr) err_next = 1'b1;
                else rdata_next = {22'b0, tgt, 1'b0, pend_mode, 3'b0, mc_pending};
            end else if (is_tbl) begin
                if (cfg.config_wr) err_next = tbl_err;
                else rdata_next = {16'b0, tbl_maxp1[tbl_idx], tbl_min[tbl_idx]};
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ARMED;
            ARMED:   if (commit) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Outputs switch on the committing edge so the old schedule finishes its period on old bounds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                tbl_min[i]   <= '0;
                tbl_maxp1[i] <= 8'(RST_MAXP1);
            end
            pend_mode            <= '0;
            tgt                  <= '0;
            cur_mode             <= '0;
            mc_pending           <= 1'b0;
            stbl_min             <= '0;
            stbl_maxp1           <= 8'(RST_MAXP1);
            cfg.config_slv_rdata <= '0;
            cfg.config_slv_error <= 1'b0;
        end else begin
            cfg.config_slv_rdata <= rdata_next;
            cfg.config_slv_error <= err_next;
            stbl_min             <= tgt_hit ? tbl_min[pend_mode] : tbl_min[cur_mode];
            if (tbl_we) begin
                tbl_min[tbl_idx]   <= cfg.config_wdata[7:0];
                tbl_maxp1[tbl_idx] <= cfg.config_wdata[15:8];
            end
            if (req_valid) begin
                pend_mode  <= req_mode;
                tgt        <= cfg.config_wdata[9:8];
                mc_pending <= 1'b1;
            end
            if (commit) begin
                cur_mode   <= pend_mode;
                stbl_maxp1 <= tbl_maxp1[pend_mode];
                mc_pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mode_change_ctrl.sv
// Bench for mode_change_ctrl: directed scenarios then randomized traffic against a behavioural model.
module tb_mode_change_ctrl;
    localparam int NMODES    = 4;
    localparam int RST_MAXP1 = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       period_boundary = 1'b0;
    logic [1:0] mc_p_cnt = 2'd0;
    logic [7:0] stbl_min, stbl_maxp1;
    logic [2:0] cur_mode;
    logic       mc_pending;

    always #5 clk = ~clk;

    mode_change_if cfg();

    mode_change_ctrl #(.NMODES(NMODES), .RST_MAXP1(RST_MAXP1)) dut (
        .clk(clk), .reset(reset), .cfg(cfg),
        .period_boundary(period_boundary), .mc_p_cnt(mc_p_cnt),
        .stbl_min(stbl_min), .stbl_maxp1(stbl_maxp1),
        .cur_mode(cur_mode), .mc_pending(mc_pending)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: schedule table, active/pending mode, and the expected outputs.
    logic [7:0]  m_min   [8];
    logic [7:0]  m_maxp1 [8];
    logic [2:0]  m_cur, m_pend;
    logic [1:0]  m_tgt;
    bit          m_armed, m_cool;
    logic [7:0]  e_min, e_maxp1;
    logic [31:0] e_rdata;
    bit          e_err;
    logic [1:0]  cnt_now = 2'd0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_min[i]   = 8'd0;
            m_maxp1[i] = 8'(RST_MAXP1);
        end
        m_cur = 0; m_pend = 0; m_tgt = 0; m_armed = 0; m_cool = 0;
        e_min = 0; e_maxp1 = 8'(RST_MAXP1); e_rdata = 0; e_err = 0;
    endtask

    task automatic model_step(input bit en, input bit s, input bit w, input logic [13:0] a,
                              input logic [31:0] d, input bit pb, input logic [1:0] cnt);
        int ofs, idx;
        bit acc, hit, commit, req;
        logic [2:0] mode;
        logic [7:0] n_min;
        ofs    = int'(a[10:0]);
        acc    = en && s;
        hit    = m_armed && (cnt == m_tgt);
        commit = hit && pb;
        n_min  = hit ? m_min[m_pend] : m_min[m_cur];
        mode   = d[2:0];
        req    = 0;
        e_err  = 0;
        e_rdata = 0;
        if (acc) begin
            if (ofs == 0) begin
                if (!w) e_rdata = {22'b0, m_tgt, 5'b0, m_cur};
                else if (int'(mode) >= NMODES || m_armed || m_cool) e_err = 1;
                else req = (mode != m_cur);
            end else if (ofs == 1) begin
                if (w) e_err = 1;
                else e_rdata = {22'b0, m_tgt, 1'b0, m_pend, 3'b0, m_armed};
            end else if (ofs >= 2 && ofs < 2 + NMODES) begin
                idx = ofs - 2;
                if (!w) e_rdata = {16'b0, m_maxp1[idx], m_min[idx]};
                else if (idx == int'(m_cur) || (m_armed && idx == int'(m_pend))) e_err = 1;
                else begin
                    m_min[idx]   = d[7:0];
                    m_maxp1[idx] = d[15:8];
                end
            end else begin
                e_err = 1;
            end
        end
        m_cool = commit;
        if (commit) begin
            m_cur   = m_pend;
            e_maxp1 = m_maxp1[m_pend];
            m_armed = 0;
        end
        if (req) begin
            m_armed = 1;
            m_pend  = mode;
            m_tgt   = d[9:8];
        end
        e_min = n_min;
    endtask

    task automatic tick(input bit en, input bit s, input bit w, input logic [13:0] a,
                        input logic [31:0] d, input bit pb);
        @(negedge clk);
        cfg.config_en = en; cfg.sel = s; cfg.config_wr = w;
        cfg.config_addr = a; cfg.config_wdata = d;
        period_boundary = pb; mc_p_cnt = cnt_now;
        @(posedge clk);
        model_step(en, s, w, a, d, pb, cnt_now);
        #1;
        cfg.config_en = 0; cfg.sel = 0; period_boundary = 0;
    endtask

    task automatic wr_cfg(input logic [13:0] a, input logic [31:0] d, input bit pb = 0);
        tick(1, 1, 1, a, d, pb);
    endtask

    task automatic rd_cfg(input logic [13:0] a);
        tick(1, 1, 0, a, 32'd0, 0);
    endtask

    task automatic idle(input bit pb = 0);
        tick(0, 0, 0, 14'd0, 32'd0, pb);
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (stbl_min !== 8'd0) begin n_bad++; $display("FAIL rst_min: got %h want 00", stbl_min); end
        n_cmp++; if (stbl_maxp1 !== 8'(RST_MAXP1)) begin n_bad++; $display("FAIL rst_maxp1: got %h want %h", stbl_maxp1, 8'(RST_MAXP1)); end
        n_cmp++; if (cur_mode !== 3'd0 || mc_pending !== 1'b0) begin n_bad++; $display("FAIL rst_mode: got mode %0d pend %b want 0 0", cur_mode, mc_pending); end
        @(negedge clk) reset = 0;
        model_reset();
        rd_cfg(14'h002);
        n_cmp++; if (cfg.config_slv_rdata !== 32'h0000_0100 || cfg.config_slv_error !== 1'b0) begin n_bad++; $display("FAIL rst_tbl0: got %h/%b want 00000100/0", cfg.config_slv_rdata, cfg.config_slv_error); end
    endtask

    task automatic test_table_rw();
        wr_cfg(14'h003, 32'h0000_1810);
        n_cmp++; if (cfg.config_slv_error !== 1'b0) begin n_bad++; $display("FAIL tbl1_wr_err: got %b want 0", cfg.config_slv_error); end
        rd_cfg(14'h003);
        n_cmp++; if (cfg.config_slv_rdata !== 32'h0000_1810 || cfg.config_slv_error !== 1'b0) begin n_bad++; $display("FAIL tbl1_rd: got %h/%b want 00001810/0", cfg.config_slv_rdata, cfg.config_slv_error); end
        wr_cfg(14'h004, 32'hABCD_2C20);
        wr_cfg(14'h005, 32'h0000_3A30);
        rd_cfg(14'h004);
        n_cmp++; if (cfg.config_slv_rdata !== 32'h0000_2C20) begin n_bad++; $display("FAIL tbl2_rd: got %h want 00002c20", cfg.config_slv_rdata); end
        wr_cfg(14'h002, 32'h0000_0505);
        n_cmp++; if (cfg.config_slv_error !== 1'b1) begin n_bad++; $display("FAIL tbl_cur_wr: got err %b want 1", cfg.config_slv_error); end
    endtask

    task automatic test_mode_change();
        cnt_now = 2'd1;
        wr_cfg(14'h000, 32'h0000_0201);
        n_cmp++; if (cfg.config_slv_error !== 1'b0 || mc_pending !== 1'b1) begin n_bad++; $display("FAIL mc_arm: got err %b pend %b want 0 1", cfg.config_slv_error, mc_pending); end
        n_cmp++; if (stbl_min !== 8'd0) begin n_bad++; $display("FAIL mc_min_idle: got %h want 00", stbl_min); end
        idle(1);
        n_cmp++; if (cur_mode !== 3'd0 || mc_pending !== 1'b1) begin n_bad++; $display("FAIL mc_wrong_boundary: got mode %0d pend %b want 0 1", cur_mode, mc_pending); end
        cnt_now = 2'd2;
        idle(0);
        n_cmp++; if (stbl_min !== 8'h10 || stbl_maxp1 !== 8'(RST_MAXP1)) begin n_bad++; $display("FAIL mc_min_early: got min %h maxp1 %h want 10 %h", stbl_min, stbl_maxp1, 8'(RST_MAXP1)); end
        idle(1);
        n_cmp++; if (stbl_maxp1 !== 8'h18 || cur_mode !== 3'd1 || mc_pending !== 1'b0) begin n_bad++; $display("FAIL mc_commit: got maxp1 %h mode %0d pend %b want 18 1 0", stbl_maxp1, cur_mode, mc_pending); end
        cnt_now = 2'd3;
        idle(0);
        rd_cfg(14'h001);
        n_cmp++; if (cfg.config_slv_rdata !== 32'h0000_0210) begin n_bad++; $display("FAIL mc_stat: got %h want 00000210", cfg.config_slv_rdata); end
        rd_cfg(14'h000);
        n_cmp++; if (cfg.config_slv_rdata !== 32'h0000_0201) begin n_bad++; $display("FAIL mc_req_rd: got %h want 00000201", cfg.config_slv_rdata); end
    endtask

    task automatic test_errors();
        wr_cfg(14'h000, 32'h0000_0002);
        n_cmp++; if (cfg.config_slv_error !== 1'b0 || mc_pending !== 1'b1) begin n_bad++; $display("FAIL err_arm: got err %b pend %b want 0 1", cfg.config_slv_error, mc_pending); end
        wr_cfg(14'h000, 32'h0000_0103);
        n_cmp++; if (cfg.config_slv_error !== 1'b1) begin n_bad++; $display("FAIL err_req_armed: got %b want 1", cfg.config_slv_error); end
        wr_cfg(14'h000, 32'(NMODES));
        n_cmp++; if (cfg.config_slv_error !== 1'b1) begin n_bad++; $display("FAIL err_req_mode: got %b want 1", cfg.config_slv_error); end
        wr_cfg(14'h001, 32'h0000_0000);
        n_cmp++; if (cfg.config_slv_error !== 1'b1) begin n_bad++; $display("FAIL err_stat_wr: got %b want 1", cfg.config_slv_error); end
        rd_cfg(14'h7FF);
        n_cmp++; if (cfg.config_slv_error !== 1'b1 || cfg.config_slv_rdata !== 32'd0) begin n_bad++; $display("FAIL err_bad_addr: got %h/%b want 0/1", cfg.config_slv_rdata, cfg.config_slv_error); end
        rd_cfg(14'h001);
        n_cmp++; if (cfg.config_slv_rdata !== 32'h0000_0021 || cur_mode !== 3'd1) begin n_bad++; $display("FAIL err_state_kept: got stat %h mode %0d want 00000021 1", cfg.config_slv_rdata, cur_mode); end
    endtask

    task automatic test_tbl_protect();
        wr_cfg(14'h003, 32'h0000_5555);
        n_cmp++; if (cfg.config_slv_error !== 1'b1) begin n_bad++; $display("FAIL prot_cur: got %b want 1", cfg.config_slv_error); end
        wr_cfg(14'h004, 32'h0000_6666);
        n_cmp++; if (cfg.config_slv_error !== 1'b1) begin n_bad++; $display("FAIL prot_pend: got %b want 1", cfg.config_slv_error); end
        rd_cfg(14'h003);
        n_cmp++; if (cfg.config_slv_rdata !== 32'h0000_1810) begin n_bad++; $display("FAIL prot_cur_rd: got %h want 00001810", cfg.config_slv_rdata); end
        rd_cfg(14'h004);
        n_cmp++; if (cfg.config_slv_rdata !== 32'h0000_2C20) begin n_bad++; $display("FAIL prot_pend_rd: got %h want 00002c20", cfg.config_slv_rdata); end
        wr_cfg(14'h005, 32'h0000_3A30);
        n_cmp++; if (cfg.config_slv_error !== 1'b0) begin n_bad++; $display("FAIL prot_other: got %b want 0", cfg.config_slv_error); end
        cnt_now = 2'd0;
        idle(0);
        n_cmp++; if (stbl_min !== 8'h20) begin n_bad++; $display("FAIL prot_min: got %h want 20", stbl_min); end
        idle(1);
        n_cmp++; if (cur_mode !== 3'd2 || stbl_maxp1 !== 8'h2C) begin n_bad++; $display("FAIL prot_commit: got mode %0d maxp1 %h want 2 2c", cur_mode, stbl_maxp1); end
    endtask

    task automatic test_same_mode();
        idle(0);
        wr_cfg(14'h000, 32'h0000_0102);
        n_cmp++; if (cfg.config_slv_error !== 1'b0 || mc_pending !== 1'b0) begin n_bad++; $display("FAIL same_req: got err %b pend %b want 0 0", cfg.config_slv_error, mc_pending); end
        n_cmp++; if (cur_mode !== 3'd2 || stbl_maxp1 !== 8'h2C || stbl_min !== 8'h20) begin n_bad++; $display("FAIL same_outputs: got %0d %h %h want 2 2c 20", cur_mode, stbl_maxp1, stbl_min); end
        cnt_now = 2'd1;
        wr_cfg(14'h000, 32'h0000_0103, 1);
        n_cmp++; if (cur_mode !== 3'd2 || mc_pending !== 1'b1) begin n_bad++; $display("FAIL req_at_boundary: got mode %0d pend %b want 2 1", cur_mode, mc_pending); end
        cnt_now = 2'd2;
        idle(1);
        n_cmp++; if (cur_mode !== 3'd2 || mc_pending !== 1'b1) begin n_bad++; $display("FAIL req_wait: got mode %0d pend %b want 2 1", cur_mode, mc_pending); end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3 reset = 1;
        #1;
        n_cmp++; if (stbl_min !== 8'd0 || stbl_maxp1 !== 8'(RST_MAXP1) || cur_mode !== 3'd0 || mc_pending !== 1'b0) begin n_bad++; $display("FAIL async_rst: got %h %h %0d %b want 00 %h 0 0", stbl_min, stbl_maxp1, cur_mode, mc_pending, 8'(RST_MAXP1)); end
        @(negedge clk) reset = 0;
        model_reset();
        cnt_now = 2'd1;
        idle(1);
        n_cmp++; if (cur_mode !== 3'd0 || mc_pending !== 1'b0) begin n_bad++; $display("FAIL async_no_commit: got mode %0d pend %b want 0 0", cur_mode, mc_pending); end
        rd_cfg(14'h003);
        n_cmp++; if (cfg.config_slv_rdata !== 32'h0000_0100) begin n_bad++; $display("FAIL async_tbl: got %h want 00000100", cfg.config_slv_rdata); end
    endtask

    task automatic test_random();
        int len, pos, kind;
        bit pb, en, s, w;
        logic [13:0] a;
        logic [31:0] d;
        len = $urandom_range(2, 5);
        pos = 0;
        for (int c = 0; c < 1500; c++) begin
            pb   = (pos == len - 1);
            en   = ($urandom_range(0, 99) < 45);
            s    = ($urandom_range(0, 9) != 0);
            w    = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 5);
            d    = $urandom();
            case (kind)
                0, 1: begin a = 14'd0; d[2:0] = 3'($urandom_range(0, NMODES)); end
                2, 3: a = 14'(2 + $urandom_range(0, NMODES - 1));
                4:    a = 14'd1;
                default: a = ($urandom_range(0, 1) != 0) ? 14'(2 + NMODES) : 14'($urandom_range(16, 2047));
            endcase
            a[13:11] = 3'($urandom_range(0, 7));
            tick(en, s, w, a, d, pb);
            n_cmp++; if (stbl_min !== e_min || stbl_maxp1 !== e_maxp1) begin n_bad++; $display("FAIL rnd_bounds c=%0d: got %h %h want %h %h", c, stbl_min, stbl_maxp1, e_min, e_maxp1); end
            n_cmp++; if (cur_mode !== m_cur || mc_pending !== m_armed) begin n_bad++; $display("FAIL rnd_mode c=%0d: got %0d %b want %0d %b", c, cur_mode, mc_pending, m_cur, m_armed); end
            if (en && s) begin
                n_cmp++; if (cfg.config_slv_rdata !== e_rdata || cfg.config_slv_error !== e_err) begin n_bad++; $display("FAIL rnd_cfg c=%0d addr %h: got %h/%b want %h/%b", c, a, cfg.config_slv_rdata, cfg.config_slv_error, e_rdata, e_err); end
            end
            if (pb) begin
                cnt_now = cnt_now + 2'd1;
                pos = 0;
                len = $urandom_range(2, 5);
            end else begin
                pos++;
            end
        end
    endtask

    initial begin
        cfg.config_en = 0; cfg.sel = 0; cfg.config_wr = 0;
        cfg.config_addr = 0; cfg.config_wdata = 0;
        model_reset();
        test_reset();
        test_table_rw();
        test_mode_change();
        test_errors();
        test_tbl_protect();
        test_same_mode();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
